// File: rtl/load_store_unit_if.sv
// Execute-stage request, data-memory bus and result signals of the load/store unit.
// The slave modport is the unit itself; the master modport is the surrounding pipeline/memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  alucode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        load_valid;
    logic [31:0] load_data;
    logic [4:0]  load_rd;
    logic        store_done;
    logic        misaligned;
    logic        bus_error;
    logic        dbg_state;

    // Handshakes: a request transfers on a cycle where req_valid && req_ready, and the
    // requester holds its inputs while req_ready=0; a bus access is mem_req held high with
    // stable attributes until a single-cycle mem_ack or the timeout abort.
    modport slave (
        input  req_valid, alucode, addr, store_data, rd_in, mem_rdata, mem_ack,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               load_valid, load_data, load_rd, store_done, misaligned, bus_error, dbg_state
    );

    modport master (
        output req_valid, alucode, addr, store_data, rd_in, mem_rdata, mem_ack,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               load_valid, load_data, load_rd, store_done, misaligned, bus_error, dbg_state
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: alignment check, byte-lane steering, load extension,
// and a bus timeout that aborts an access when mem_ack never arrives.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  lsu
);

    localparam logic [5:0] ALU_LB  = 6'd20;
    localparam logic [5:0] ALU_LH  = 6'd21;
    localparam logic [5:0] ALU_LW  = 6'd22;
    localparam logic [5:0] ALU_LBU = 6'd23;
    localparam logic [5:0] ALU_LHU = 6'd24;
    localparam logic [5:0] ALU_SB  = 6'd25;
    localparam logic [5:0] ALU_SH  = 6'd26;
    localparam logic [5:0] ALU_SW  = 6'd27;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Counter only has to reach TIMEOUT_CYCLES-1: the abort fires on the cycle that would make it TIMEOUT_CYCLES.
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [3:0]    r_mem_be;
    logic [31:0]   r_mem_wdata;
    logic          r_load_valid;
    logic [31:0]   r_load_data;
    logic [4:0]    r_load_rd;
    logic          r_store_done;
    logic          r_misaligned;
    logic          r_bus_error;
    logic          r_is_load;
    logic          r_unsigned;
    logic [1:0]    r_size;
    logic [1:0]    r_lo;
    logic [4:0]    r_rd;

    logic          w_is_load;
    logic          w_is_store;
    logic          w_unsigned;
    logic [1:0]    w_size;
    logic          w_misal;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_unsigned = 1'b0;
        w_size     = SZ_B;
        case (lsu.alucode)
            ALU_LB:  begin w_is_load  = 1'b1; w_size = SZ_B; end
            ALU_LH:  begin w_is_load  = 1'b1; w_size = SZ_H; end
            ALU_LW:  begin w_is_load  = 1'b1; w_size = SZ_W; end
            ALU_LBU: begin w_is_load  = 1'b1; w_size = SZ_B; w_unsigned = 1'b1; end
            ALU_LHU: begin w_is_load  = 1'b1; w_size = SZ_H; w_unsigned = 1'b1; end
            ALU_SB:  begin w_is_store = 1'b1; w_size = SZ_B; end
            ALU_SH:  begin w_is_store = 1'b1; w_size = SZ_H; end
            ALU_SW:  begin w_is_store = 1'b1; w_size = SZ_W; end
            default: ;
        endcase
    end

    always_comb begin
        w_misal = 1'b0;
        w_be    = 4'b1111;
        w_wdata = 32'h0;
        case (w_size)
            SZ_B: begin
                w_be = 4'b0001 << lsu.addr[1:0];
                if (w_is_store) w_wdata = {4{lsu.store_data[7:0]}};
            end
            SZ_H: begin
                w_misal = lsu.addr[0];
                w_be    = lsu.addr[1] ? 4'b1100 : 4'b0011;
                if (w_is_store) w_wdata = {2{lsu.store_data[15:0]}};
            end
            default: begin
                w_misal = (lsu.addr[1:0] != 2'b00);
                if (w_is_store) w_wdata = lsu.store_data;
            end
        endcase
    end

    always_comb begin
        w_byte = 8'h0;
        case (r_lo)
            2'd0: w_byte = lsu.mem_rdata[7:0];
            2'd1: w_byte = lsu.mem_rdata[15:8];
            2'd2: w_byte = lsu.mem_rdata[23:16];
            default: w_byte = lsu.mem_rdata[31:24];
        endcase
        w_half = r_lo[1] ? lsu.mem_rdata[31:16] : lsu.mem_rdata[15:0];
        case (r_size)
            SZ_B:    w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = lsu.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_be     <= 4'h0;
            r_mem_wdata  <= 32'h0;
            r_load_valid <= 1'b0;
            r_load_data  <= 32'h0;
            r_load_rd    <= 5'h0;
            r_store_done <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            r_is_load    <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= SZ_B;
            r_lo         <= 2'b00;
            r_rd         <= 5'h0;
        end else begin
            r_load_valid <= 1'b0;
            r_store_done <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (lsu.req_valid) begin
                        r_is_load  <= w_is_load;
                        r_unsigned <= w_unsigned;
                        r_size     <= w_size;
                        r_lo       <= lsu.addr[1:0];
                        r_rd       <= lsu.rd_in;
                        // Unknown opcodes fall through silently; misaligned ones never reach the bus.
                        if (w_is_load || w_is_store) begin
                            if (w_misal) begin
                                r_misaligned <= 1'b1;
                            end else begin
                                r_state     <= S_BUS;
                                r_cnt       <= '0;
                                r_mem_req   <= 1'b1;
                                r_mem_we    <= w_is_store;
                                r_mem_addr  <= {lsu.addr[31:2], 2'b00};
                                r_mem_be    <= w_be;
                                r_mem_wdata <= w_wdata;
                            end
                        end
                    end
                end
                S_BUS: begin
                    if (lsu.mem_ack) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                        if (r_is_load) begin
                            r_load_valid <= 1'b1;
                            r_load_data  <= w_load;
                            r_load_rd    <= r_rd;
                        end else begin
                            r_store_done <= 1'b1;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= S_IDLE;
                        r_mem_req   <= 1'b0;
                        r_bus_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign lsu.req_ready  = (r_state == S_IDLE) && !rst;
    assign lsu.mem_req    = r_mem_req;
    assign lsu.mem_we     = r_mem_we;
    assign lsu.mem_addr   = r_mem_addr;
    assign lsu.mem_be     = r_mem_be;
    assign lsu.mem_wdata  = r_mem_wdata;
    assign lsu.load_valid = r_load_valid;
    assign lsu.load_data  = r_load_data;
    assign lsu.load_rd    = r_load_rd;
    assign lsu.store_done = r_store_done;
    assign lsu.misaligned = r_misaligned;
    assign lsu.bus_error  = r_bus_error;
    assign lsu.dbg_state  = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads/stores, alignment rejects, timeout and mid-access reset.
module tb_load_store_unit;

    localparam logic [5:0] ALU_LB  = 6'd20;
    localparam logic [5:0] ALU_LH  = 6'd21;
    localparam logic [5:0] ALU_LW  = 6'd22;
    localparam logic [5:0] ALU_LBU = 6'd23;
    localparam logic [5:0] ALU_LHU = 6'd24;
    localparam logic [5:0] ALU_SB  = 6'd25;
    localparam logic [5:0] ALU_SH  = 6'd26;
    localparam logic [5:0] ALU_SW  = 6'd27;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    load_store_unit_if u_if ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .lsu (u_if)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd);
        u_if.req_valid  = 1'b1;
        u_if.alucode    = op;
        u_if.addr       = a;
        u_if.store_data = sd;
        u_if.rd_in      = rd;
        tick();
        u_if.req_valid  = 1'b0;
    endtask

    task automatic ack_with(input logic [31:0] rdata);
        u_if.mem_ack   = 1'b1;
        u_if.mem_rdata = rdata;
        tick();
        u_if.mem_ack   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst             = 1'b1;
        u_if.req_valid  = 1'b0;
        u_if.alucode    = 6'd0;
        u_if.addr       = 32'h0;
        u_if.store_data = 32'h0;
        u_if.rd_in      = 5'd0;
        u_if.mem_rdata  = 32'h0;
        u_if.mem_ack    = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 32'(u_if.req_ready), 32'h0);
        check("rst_mem_req", 32'(u_if.mem_req), 32'h0);
        check("rst_load_data", u_if.load_data, 32'h0);
        check("rst_load_rd", 32'(u_if.load_rd), 32'h0);
        check("rst_pulses", 32'({u_if.load_valid, u_if.store_done, u_if.misaligned, u_if.bus_error}), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(u_if.req_ready), 32'h1);

        // LB from the top byte, sign-extended
        issue(ALU_LB, 32'h0000_1003, 32'h0, 5'd5);
        check("lb_mem_req", 32'(u_if.mem_req), 32'h1);
        check("lb_ready_busy", 32'(u_if.req_ready), 32'h0);
        check("lb_mem_addr", u_if.mem_addr, 32'h0000_1000);
        check("lb_mem_be", 32'(u_if.mem_be), 32'h8);
        check("lb_mem_we", 32'(u_if.mem_we), 32'h0);
        check("lb_wdata", u_if.mem_wdata, 32'h0);
        ack_with(32'h80FF_1234);
        check("lb_valid", 32'(u_if.load_valid), 32'h1);
        check("lb_data", u_if.load_data, 32'hFFFF_FF80);
        check("lb_rd", 32'(u_if.load_rd), 32'd5);
        check("lb_done_req", 32'(u_if.mem_req), 32'h0);
        check("lb_done_ready", 32'(u_if.req_ready), 32'h1);

        // back-to-back LHU accepted at A+1
        issue(ALU_LHU, 32'h0000_2002, 32'h0, 5'd7);
        check("lhu_mem_req", 32'(u_if.mem_req), 32'h1);
        check("lhu_valid_low", 32'(u_if.load_valid), 32'h0);
        check("lb_data_hold", u_if.load_data, 32'hFFFF_FF80);
        check("lhu_mem_be", 32'(u_if.mem_be), 32'hC);
        check("lhu_mem_addr", u_if.mem_addr, 32'h0000_2000);
        ack_with(32'h8001_0000);
        check("lhu_valid", 32'(u_if.load_valid), 32'h1);
        check("lhu_data", u_if.load_data, 32'h0000_8001);
        check("lhu_rd", 32'(u_if.load_rd), 32'd7);

        issue(ALU_LH, 32'h0000_2000, 32'h0, 5'd9);
        check("lh_mem_be", 32'(u_if.mem_be), 32'h3);
        ack_with(32'h0000_8001);
        check("lh_data", u_if.load_data, 32'hFFFF_8001);

        issue(ALU_LBU, 32'h0000_1001, 32'h0, 5'd10);
        check("lbu_mem_be", 32'(u_if.mem_be), 32'h2);
        ack_with(32'h0000_A500);
        check("lbu_data", u_if.load_data, 32'h0000_00A5);

        issue(ALU_LW, 32'h0000_3000, 32'h0, 5'd11);
        check("lw_mem_be", 32'(u_if.mem_be), 32'hF);
        ack_with(32'h1234_5678);
        check("lw_data", u_if.load_data, 32'h1234_5678);
        check("lw_rd", 32'(u_if.load_rd), 32'd11);

        // SB with 3 wait cycles; ack lands on the last allowed cycle and must win
        issue(ALU_SB, 32'h0000_0011, 32'hDEAD_BEA5, 5'd0);
        for (int i = 0; i < 3; i++) begin
            check("sb_mem_req", 32'(u_if.mem_req), 32'h1);
            check("sb_wdata", u_if.mem_wdata, 32'hA5A5_A5A5);
            check("sb_mem_be", 32'(u_if.mem_be), 32'h2);
            check("sb_mem_we", 32'(u_if.mem_we), 32'h1);
            check("sb_mem_addr", u_if.mem_addr, 32'h0000_0010);
            tick();
        end
        check("sb_req_last", 32'(u_if.mem_req), 32'h1);
        ack_with(32'h0);
        check("sb_store_done", 32'(u_if.store_done), 32'h1);
        check("sb_no_bus_error", 32'(u_if.bus_error), 32'h0);
        check("sb_no_load_valid", 32'(u_if.load_valid), 32'h0);
        check("sb_req_drop", 32'(u_if.mem_req), 32'h0);
        tick();
        check("sb_done_pulse", 32'(u_if.store_done), 32'h0);

        // SH; a request raised while busy must not be taken
        issue(ALU_SH, 32'h0000_0022, 32'h0000_BEEF, 5'd0);
        check("sh_wdata", u_if.mem_wdata, 32'hBEEF_BEEF);
        check("sh_mem_be", 32'(u_if.mem_be), 32'hC);
        u_if.req_valid = 1'b1;
        u_if.alucode   = ALU_LB;
        u_if.addr      = 32'h0000_0999;
        ack_with(32'h0);
        check("sh_store_done", 32'(u_if.store_done), 32'h1);
        check("sh_mem_addr_kept", u_if.mem_addr, 32'h0000_0020);
        u_if.req_valid = 1'b0;
        tick();
        check("busy_req_ignored", 32'(u_if.mem_req), 32'h0);

        issue(ALU_SW, 32'h0000_0040, 32'h1122_3344, 5'd0);
        check("sw_wdata", u_if.mem_wdata, 32'h1122_3344);
        check("sw_mem_be", 32'(u_if.mem_be), 32'hF);
        ack_with(32'h0);
        check("sw_store_done", 32'(u_if.store_done), 32'h1);

        // alignment rejects
        issue(ALU_SW, 32'h0000_0006, 32'hFFFF_FFFF, 5'd0);
        check("sw_misaligned", 32'(u_if.misaligned), 32'h1);
        check("sw_mis_no_req", 32'(u_if.mem_req), 32'h0);
        check("sw_mis_ready", 32'(u_if.req_ready), 32'h1);
        tick();
        check("sw_mis_pulse", 32'(u_if.misaligned), 32'h0);
        check("sw_mis_no_req2", 32'(u_if.mem_req), 32'h0);
        issue(ALU_LH, 32'h0000_2001, 32'h0, 5'd3);
        check("lh_misaligned", 32'(u_if.misaligned), 32'h1);
        check("lh_mis_no_req", 32'(u_if.mem_req), 32'h0);

        // non-memory opcode dropped silently
        issue(6'd0, 32'h0000_0100, 32'h0, 5'd4);
        check("drop_pulses", 32'({u_if.mem_req, u_if.load_valid, u_if.store_done, u_if.misaligned, u_if.bus_error}), 32'h0);
        check("drop_ready", 32'(u_if.req_ready), 32'h1);

        // timeout: mem_req high exactly 4 cycles, then bus_error
        issue(ALU_LW, 32'h0000_0100, 32'h0, 5'd12);
        for (int i = 0; i < 4; i++) begin
            check("to_mem_req", 32'(u_if.mem_req), 32'h1);
            tick();
        end
        check("to_req_drop", 32'(u_if.mem_req), 32'h0);
        check("to_bus_error", 32'(u_if.bus_error), 32'h1);
        check("to_no_load_valid", 32'(u_if.load_valid), 32'h0);
        check("to_ready", 32'(u_if.req_ready), 32'h1);
        ack_with(32'hAAAA_AAAA);
        check("late_ack_no_valid", 32'(u_if.load_valid), 32'h0);
        check("late_ack_no_req", 32'(u_if.mem_req), 32'h0);
        check("late_ack_err_pulse", 32'(u_if.bus_error), 32'h0);
        check("late_ack_data_hold", u_if.load_data, 32'h1234_5678);

        // reset on the 2nd BUS cycle, ack afterwards must not complete
        issue(ALU_LW, 32'h0000_0200, 32'h0, 5'd13);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_req", 32'(u_if.mem_req), 32'h0);
        check("mid_rst_ready", 32'(u_if.req_ready), 32'h0);
        check("mid_rst_load_data", u_if.load_data, 32'h0);
        check("mid_rst_load_rd", 32'(u_if.load_rd), 32'h0);
        check("mid_rst_pulses", 32'({u_if.load_valid, u_if.store_done, u_if.misaligned, u_if.bus_error}), 32'h0);
        rst = 1'b0;
        ack_with(32'h5555_5555);
        check("post_rst_no_valid", 32'(u_if.load_valid), 32'h0);
        check("post_rst_ready2", 32'(u_if.req_ready), 32'h1);
        issue(ALU_LW, 32'h0000_0300, 32'h0, 5'd14);
        check("rec_mem_addr", u_if.mem_addr, 32'h0000_0300);
        ack_with(32'hCAFE_F00D);
        check("rec_valid", 32'(u_if.load_valid), 32'h1);
        check("rec_data", u_if.load_data, 32'hCAFE_F00D);
        check("rec_rd", 32'(u_if.load_rd), 32'd14);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles mem_req is held without mem_ack before the access is aborted.
REQ-002 SHALL use one clock; reset is synchronous and active-high. Ports `clk` and `rst` SHALL be the only clock and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  access request from the execute stage.
REQ-006 req_ready  output  1  unit idle, so a request is accepted this cycle.
REQ-007 alucode  input  6  `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW` per define.vh.
REQ-008 addr  input  32  effective byte address (op1+op2 from the ALU).
REQ-009 store_data  input  32  rs2 value; the low byte/half/word is used.
REQ-010 rd_in  input  5  load destination register.
REQ-011 mem_req  output  1  bus request, held until mem_ack or timeout.
REQ-012 mem_we  output  1  1 = write.
REQ-013 mem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-014 mem_be  output  4  byte-lane enables.
REQ-015 mem_wdata  output  32  lane-replicated store data.
REQ-016 mem_rdata  input  32  read word, valid when mem_ack=1.
REQ-017 mem_ack  input  1  single-cycle bus completion.
REQ-018 load_valid  output  1  one-cycle pulse; load_data and load_rd are valid.
REQ-019 load_data  output  32  extended load result.
REQ-020 load_rd  output  5  destination register for load_data.
REQ-021 store_done  output  1  one-cycle pulse when a store has completed.
REQ-022 misaligned  output  1  one-cycle pulse when a request is rejected for alignment.
REQ-023 bus_error  output  1  one-cycle pulse when an access is aborted by timeout.

Function
REQ-024 SHALL implement the FSM states IDLE and BUS.
REQ-025 IDLE: req_ready=1 and mem_req=0.
REQ-026 BUS: req_ready=0 and mem_req=1.
REQ-027 Accept SHALL occur when req_valid && req_ready; alucode, addr, store_data and rd_in SHALL be latched on accept.
REQ-028 When the accepted alucode is not a load or store, the request SHALL be dropped: state stays IDLE and no output pulses.
REQ-029 Alignment rules: LH, LHU and SH require addr[0]=0; LW and SW require addr[1:0]=0.
REQ-030 A request that violates REQ-029 SHALL pulse misaligned in the cycle after accept, make no bus access, and stay in IDLE.
REQ-031 An aligned access accepted at cycle T SHALL assert mem_req from T+1 and enter BUS.
REQ-032 mem_addr, mem_we, mem_be and mem_wdata SHALL be stable while mem_req=1.
REQ-033 mem_be SHALL be: B = 4'b0001<<addr[1:0]; H = addr[1] ? 4'b1100 : 4'b0011; W = 4'b1111 (loads and stores alike).
REQ-034 mem_wdata SHALL be: SB = byte replicated x4; SH = half replicated x2; SW = word.
REQ-035 mem_wdata SHALL be 0 for loads.
REQ-036 mem_ack seen in BUS at cycle A (A may equal T+1) SHALL cause, at A+1: mem_req=0, state IDLE, req_ready=1.
REQ-037 For a store, mem_ack at cycle A SHALL pulse store_done at A+1.
REQ-038 For a load, mem_ack at cycle A SHALL pulse load_valid at A+1, with load_data and load_rd registered from the cycle-A values.
REQ-039 Load extraction: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW selects the full word.
REQ-040 LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend.
REQ-041 load_data and load_rd SHALL hold their last value when load_valid=0.
REQ-042 In BUS, a cycle counter SHALL increment on every cycle without mem_ack.
REQ-043 When the count reaches TIMEOUT_CYCLES, the next cycle SHALL have mem_req=0, bus_error pulsed, state IDLE, and no load_valid or store_done.
REQ-044 mem_ack arriving on the same cycle the count reaches TIMEOUT_CYCLES SHALL win: the access completes normally.
REQ-045 mem_ack outside BUS SHALL be ignored.
REQ-046 req_valid while req_ready=0 SHALL NOT be accepted; the requester holds its inputs.
REQ-047 Throughput SHALL be at most one access in flight; back-to-back accesses SHALL be possible with a new accept at A+1.

Reset
REQ-048 While rst=1, at the next edge: state SHALL be IDLE and the counter 0.
REQ-049 While rst=1, at the next edge: all outputs SHALL be 0, including req_ready, load_data and load_rd.
REQ-050 req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-051 rst during BUS SHALL drop mem_req the next cycle, with no pulse outputs and no completion on a later mem_ack.

Verification
REQ-052 LB, addr=0x1003, rdata=0x80FF_1234, ack at T+1 -> load_valid at T+2, load_data=0xFFFF_FF80, mem_addr=0x1000, mem_be=4'b1000.
REQ-053 LHU, addr=0x2002, rdata=0x8001_0000 -> load_data=0x0000_8001, mem_be=4'b1100.
REQ-054 SB, addr=0x11, store_data=0xDEAD_BEA5, ack after 3 wait cycles -> mem_wdata=0xA5A5_A5A5, mem_be=4'b0010, mem_we=1, inputs stable; store_done one cycle after ack.
REQ-055 SW, addr=0x06 -> misaligned pulse, mem_req never asserted, req_ready=1 the next cycle.
REQ-056 TIMEOUT_CYCLES=4, LW, no ack -> mem_req high exactly 4 cycles, then bus_error pulse, no load_valid; a late mem_ack is ignored.
REQ-057 rst asserted on the 2nd BUS cycle of an LW, ack supplied afterwards -> all outputs 0, no load_valid; the next LW completes normally.
